// File: rtl/signed_avg_sat.sv
// Block averager: sums N = 2^LOG2_N signed samples, then holds a rounded,
// saturated average until the consumer handshakes it.
module signed_avg_sat #(
  parameter int unsigned IN_W   = 15,
  parameter int unsigned LOG2_N = 2,
  parameter int unsigned OUT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);

  localparam int unsigned ACC_W = IN_W + LOG2_N + 1;
  localparam int unsigned N     = 1 << LOG2_N;

  localparam logic [LOG2_N-1:0]       CNT_LAST = LOG2_N'(N - 1);
  localparam logic signed [ACC_W-1:0] RND      = ACC_W'(1 << (LOG2_N - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = -ACC_W'(1 << (OUT_W - 1));

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic signed [ACC_W-1:0]   r_acc;
  logic [LOG2_N-1:0]         r_cnt;
  logic signed [OUT_W-1:0]   r_out_data;
  logic                      r_out_sat;

  logic                      w_accept;
  logic                      w_last;
  logic signed [ACC_W-1:0]   w_ext;
  logic signed [ACC_W-1:0]   w_sum;
  logic signed [ACC_W-1:0]   w_rnd;
  logic signed [ACC_W-1:0]   w_avg;
  logic signed [OUT_W-1:0]   w_sat_data;
  logic                      w_sat_flag;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_ACCUM;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and accept decode; flush outranks a same-cycle sample
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_ACCUM: begin
        if (!flush && in_valid) begin
          w_accept = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_last       = 1'b1;
            w_next_state = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_next_state = S_ACCUM;
        end
      end
      default: w_next_state = S_ACCUM;
    endcase
  end

  // Sum including the current sample, round half up, arithmetic shift, clip
  always_comb begin
    w_ext      = ACC_W'(in_data);
    w_sum      = r_acc + w_ext;
    w_rnd      = w_sum + RND;
    w_avg      = w_rnd >>> LOG2_N;
    w_sat_flag = 1'b0;
    w_sat_data = OUT_W'(w_avg);
    if (w_avg > SAT_MAX) begin
      w_sat_data = OUT_W'(SAT_MAX);
      w_sat_flag = 1'b1;
    end else if (w_avg < SAT_MIN) begin
      w_sat_data = OUT_W'(SAT_MIN);
      w_sat_flag = 1'b1;
    end
  end

  // Accumulator is cleared as soon as the result is captured, so HOLD exits clean
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else if (r_state == S_ACCUM && flush) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_acc      <= '0;
        r_cnt      <= '0;
        r_out_data <= w_sat_data;
        r_out_sat  <= w_sat_flag;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + LOG2_N'(1);
      end
    end
  end

  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_HOLD);
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule

// File: doc/signed_avg_sat.md
SIGNED_AVG_SAT -- requirements
Module: signed_avg_sat

Interface
REQ-001 The block SHALL have parameter IN_W, default 15, meaning the signed input sample width (matches the signed product width of the upstream arithmetic stage).
REQ-002 The block SHALL have parameter LOG2_N, default 2, meaning the block averages N = 2^LOG2_N samples; legal range is 1..4.
REQ-003 The block SHALL have parameter OUT_W, default 8, meaning the signed output width.
REQ-004 clk  input  1  the single clock; all logic is on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 flush  input  1  synchronous discard of any partial accumulation.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_data  input  IN_W  signed sample.
REQ-009 in_ready  output  1  the block accepts a sample this cycle.
REQ-010 out_valid  output  1  out_data and out_sat are valid.
REQ-011 out_ready  input  1  the consumer accepts the output this cycle.
REQ-012 out_data  output  OUT_W  signed, rounded, saturated average.
REQ-013 out_sat  output  1  out_data was clipped by saturation.

Function
REQ-014 The block SHALL implement a two-state FSM: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 A sample SHALL be accepted only on a cycle where in_valid=1 and in_ready=1; the accepted sample is sign-extended and added to a signed accumulator of width IN_W+LOG2_N+1.
REQ-016 A LOG2_N-bit sample counter SHALL increment on each accepted sample; accepting the Nth sample (counter = N-1) SHALL move the FSM to HOLD on the next edge.
REQ-017 On entry to HOLD, out_data SHALL be registered as sat((sum + 2^(LOG2_N-1)) >>> LOG2_N), where >>> is an arithmetic shift and sum includes the Nth sample.
REQ-018 Saturation SHALL clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-128, 127] by default; out_sat SHALL be 1 exactly when clipping occurred.
REQ-019 Latency SHALL be one cycle: out_valid rises on the edge after the Nth sample is accepted.
REQ-020 In HOLD, out_data, out_sat and out_valid SHALL remain stable until out_valid=1 and out_ready=1 on the same cycle.
REQ-021 On the out_valid/out_ready handshake, the FSM SHALL return to ACCUM, with the accumulator and counter cleared to 0; no sample is accepted in that cycle, because in_ready=0 in HOLD.
REQ-022 While in HOLD, in_valid SHALL be ignored; upstream is stalled by in_ready=0.
REQ-023 flush=1 in ACCUM SHALL clear the accumulator and counter; a sample presented in the same cycle SHALL be discarded, because flush has priority.
REQ-024 flush=1 in HOLD SHALL have no effect; the pending result is preserved.
REQ-025 The accumulator SHALL never overflow for any N samples in the full IN_W signed range.
REQ-026 out_data and out_sat SHALL retain their last value while out_valid=0.

Reset
REQ-027 rst=1 at a rising edge SHALL force: FSM=ACCUM, accumulator=0, counter=0, out_valid=0, out_data=0, out_sat=0; in_ready=1 on the following cycle.
REQ-028 rst SHALL override flush, in_valid and out_ready, and SHALL abort any partial accumulation or pending HOLD result without emitting it.

Verification
REQ-029 The bench SHALL cover: with N=4 and out_ready=1, samples 10, 20, 30, 41 -> one cycle after the 4th sample, out_valid=1, out_data=25, out_sat=0.
REQ-030 The bench SHALL cover: samples -3, -3, -3, -2 -> out_data=-3, out_sat=0 (sum -11, plus 2 gives -9, arithmetic shift gives -3).
REQ-031 The bench SHALL cover: samples 100, 200, 300, 400 -> out_data=127, out_sat=1; and four samples of -16384 -> out_data=-128, out_sat=1.
REQ-032 The bench SHALL cover: result pending with out_ready=0 for 3 cycles and in_valid=1 continuously -> in_ready=0, out_data stable, no sample absorbed; out_ready=1 -> ACCUM next cycle, and the next 4 samples produce an independent result.
REQ-033 The bench SHALL cover: 2 samples accepted, then flush=1 with in_valid=1 -> that sample is dropped; the next 4 samples 8, 8, 8, 8 -> out_data=8.
REQ-034 The bench SHALL cover: rst=1 while in HOLD -> next cycle out_valid=0, out_data=0, in_ready=1; the held result is never handshaken.
